// File: rtl/modulo_avaliador_ataque.sv
// Attack evaluator for the naval-battle board: judges each confirmed attack and holds the result colour.
// Optional macro MISS_LIMIT_EN: after MAX_MISSES misses the game ends as a loss.
module modulo_avaliador_ataque #(
   parameter int SHOW_CYCLES = 25000000,
   parameter int MAX_MISSES  = 20
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        board_load,
   input  logic [34:0] board,
   input  logic        atk_valid,
   input  logic [2:0]  atk_row,
   input  logic [2:0]  atk_col,
   output logic        busy,
   output logic        result_valid,
   output logic [1:0]  rgb_output,
   output logic [5:0]  hits_remaining,
   output logic [5:0]  miss_count,
   output logic [34:0] attack_map,
   output logic [34:0] hit_map,
   output logic        game_over
);

   localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);

   // Without the limit the threshold sits beyond the saturating counter, so misses never end a game.
`ifdef MISS_LIMIT_EN
   localparam int MISS_LIMIT = MAX_MISSES;
`else
   localparam int MISS_LIMIT = MAX_MISSES + 64;
`endif

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_CHECK     = 2'd1;
   localparam logic [1:0] S_SHOW      = 2'd2;
   localparam logic [1:0] S_GAME_OVER = 2'd3;

   localparam logic [1:0] RGB_OFF  = 2'b00;
   localparam logic [1:0] RGB_MISS = 2'b01;
   localparam logic [1:0] RGB_HIT  = 2'b10;
   localparam logic [1:0] RGB_BAD  = 2'b11;

   function automatic logic [5:0] popcount35(input logic [34:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 35; i++) n = n + {5'd0, v[i]};
      return n;
   endfunction

   function automatic logic [5:0] sat_inc6(input logic [5:0] v);
      return (v == 6'h3F) ? v : v + 6'd1;
   endfunction

   logic [1:0]       state;
   logic [CNT_W-1:0] show_cnt;
   logic [34:0]      board_q;
   logic [2:0]       atk_row_p0;
   logic [2:0]       atk_col_p0;

   logic             coord_ok;
   logic [5:0]       cell_lin;
   logic [5:0]       cell_idx;
   logic [34:0]      cell_mask;
   logic             is_repeat;
   logic             is_hit;
   logic             miss_limit_hit;

   // Bit 34 is row 0 / col 0, so the linear cell number counts down from the MSB.
   assign coord_ok       = (atk_row_p0 <= 3'd6) && (atk_col_p0 <= 3'd4);
   assign cell_lin       = ({3'd0, atk_row_p0} * 6'd5) + {3'd0, atk_col_p0};
   assign cell_idx       = 6'd34 - cell_lin;
   assign cell_mask      = coord_ok ? (35'd1 << cell_idx) : '0;
   assign is_repeat      = |(attack_map & cell_mask);
   assign is_hit         = |(board_q & cell_mask);
   assign miss_limit_hit = (32'(miss_count) >= MISS_LIMIT);

   assign busy      = (state != S_IDLE);
   assign game_over = (state == S_GAME_OVER);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state          <= S_IDLE;
         show_cnt       <= '0;
         board_q        <= '0;
         atk_row_p0     <= '0;
         atk_col_p0     <= '0;
         attack_map     <= '0;
         hit_map        <= '0;
         hits_remaining <= '0;
         miss_count     <= '0;
         rgb_output     <= RGB_OFF;
         result_valid   <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (board_load) begin
            board_q        <= board;
            attack_map     <= '0;
            hit_map        <= '0;
            miss_count     <= '0;
            hits_remaining <= popcount35(board);
            rgb_output     <= RGB_OFF;
            show_cnt       <= '0;
            state          <= (popcount35(board) != 6'd0) ? S_IDLE : S_GAME_OVER;
         end else begin
            case (state)
               S_IDLE: begin
                  if (atk_valid) begin
                     atk_row_p0 <= atk_row;
                     atk_col_p0 <= atk_col;
                     state      <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  result_valid <= 1'b1;
                  show_cnt     <= SHOW_LOAD;
                  state        <= S_SHOW;
                  if (!coord_ok || is_repeat) begin
                     rgb_output <= RGB_BAD;
                  end else if (is_hit) begin
                     attack_map     <= attack_map | cell_mask;
                     hit_map        <= hit_map | cell_mask;
                     hits_remaining <= hits_remaining - 6'd1;
                     rgb_output     <= RGB_HIT;
                  end else begin
                     attack_map <= attack_map | cell_mask;
                     miss_count <= sat_inc6(miss_count);
                     rgb_output <= RGB_MISS;
                  end
               end
               S_SHOW: begin
                  if (show_cnt == '0) begin
                     // A sunk fleet wins even if the same shot also reached the miss limit.
                     if (hits_remaining == 6'd0) begin
                        rgb_output <= RGB_HIT;
                        state      <= S_GAME_OVER;
                     end else if (miss_limit_hit) begin
                        rgb_output <= RGB_MISS;
                        state      <= S_GAME_OVER;
                     end else begin
                        rgb_output <= RGB_OFF;
                        state      <= S_IDLE;
                     end
                  end else begin
                     show_cnt <= show_cnt - 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_modulo_avaliador_ataque.sv
// Directed bench for modulo_avaliador_ataque with a short show time and a two-miss limit.
module tb_modulo_avaliador_ataque;

   localparam int SHOW = 4;
   localparam int MAXM = 2;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        board_load = 1'b0;
   logic [34:0] board = '0;
   logic        atk_valid = 1'b0;
   logic [2:0]  atk_row = '0;
   logic [2:0]  atk_col = '0;
   logic        busy;
   logic        result_valid;
   logic [1:0]  rgb_output;
   logic [5:0]  hits_remaining;
   logic [5:0]  miss_count;
   logic [34:0] attack_map;
   logic [34:0] hit_map;
   logic        game_over;

   int n_checks = 0;
   int n_fail   = 0;

   modulo_avaliador_ataque #(.SHOW_CYCLES(SHOW), .MAX_MISSES(MAXM)) dut (
      .clk(clk), .clr(clr), .board_load(board_load), .board(board),
      .atk_valid(atk_valid), .atk_row(atk_row), .atk_col(atk_col),
      .busy(busy), .result_valid(result_valid), .rgb_output(rgb_output),
      .hits_remaining(hits_remaining), .miss_count(miss_count),
      .attack_map(attack_map), .hit_map(hit_map), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One attack from strobe to the end of the show window; optionally pokes a strobe mid-show.
   task automatic attack(input string tag, input logic [2:0] r, input logic [2:0] c,
                         input logic [1:0] exp_rgb, input bit poke,
                         input logic [1:0] end_rgb, input logic end_busy);
      atk_row = r; atk_col = c; atk_valid = 1'b1;
      @(negedge clk);
      atk_valid = 1'b0;
      check({tag, ".busy_check"}, busy, 1'b1);
      check({tag, ".rv_early"}, result_valid, 1'b0);
      @(negedge clk);
      check({tag, ".rv"}, result_valid, 1'b1);
      check({tag, ".rgb"}, rgb_output, exp_rgb);
      if (poke) begin
         atk_row = 3'd6; atk_col = 3'd4; atk_valid = 1'b1;
      end
      @(negedge clk);
      atk_valid = 1'b0;
      check({tag, ".rv_once"}, result_valid, 1'b0);
      repeat (SHOW - 2) @(negedge clk);
      check({tag, ".rgb_held"}, rgb_output, exp_rgb);
      check({tag, ".busy_show"}, busy, 1'b1);
      @(negedge clk);
      check({tag, ".rgb_end"}, rgb_output, end_rgb);
      check({tag, ".busy_end"}, busy, end_busy);
      check({tag, ".go_end"}, game_over, end_busy);
   endtask

   task automatic load(input logic [34:0] b);
      board = b; board_load = 1'b1;
      @(negedge clk);
      board_load = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst.busy", busy, 1'b0);
      check("rst.rgb", rgb_output, 2'b00);
      check("rst.hits", hits_remaining, 6'd0);
      check("rst.amap", attack_map, 35'd0);
      check("rst.go", game_over, 1'b0);
      check("rst.rv", result_valid, 1'b0);
      clr = 1'b1;
      @(negedge clk);

      load(35'h6_0000_0001);
      check("load.hits", hits_remaining, 6'd3);
      check("load.busy", busy, 1'b0);
      check("load.rgb", rgb_output, 2'b00);
      board = '1;

      attack("hit01", 3'd0, 3'd1, 2'b10, 1'b0, 2'b00, 1'b0);
      check("hit01.hmap", hit_map, 35'h2_0000_0000);
      check("hit01.hits", hits_remaining, 6'd2);

      attack("miss32", 3'd3, 3'd2, 2'b01, 1'b0, 2'b00, 1'b0);
      check("miss32.miss", miss_count, 6'd1);
      check("miss32.amap", attack_map, 35'h2_0002_0000);

      attack("rep32", 3'd3, 3'd2, 2'b11, 1'b0, 2'b00, 1'b0);
      check("rep32.miss", miss_count, 6'd1);
      check("rep32.amap", attack_map, 35'h2_0002_0000);
      check("rep32.hmap", hit_map, 35'h2_0000_0000);

      attack("inv70", 3'd7, 3'd0, 2'b11, 1'b0, 2'b00, 1'b0);
      check("inv70.amap", attack_map, 35'h2_0002_0000);

      attack("hit00", 3'd0, 3'd0, 2'b10, 1'b1, 2'b00, 1'b0);
      check("drop.hits", hits_remaining, 6'd1);
      @(negedge clk);
      check("drop.busy", busy, 1'b0);

      attack("hit64", 3'd6, 3'd4, 2'b10, 1'b0, 2'b10, 1'b1);
      check("win.hits", hits_remaining, 6'd0);
      check("win.hmap", hit_map, 35'h6_0000_0001);

      atk_row = 3'd3; atk_col = 3'd3; atk_valid = 1'b1;
      @(negedge clk);
      atk_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("go.rgb", rgb_output, 2'b10);
      check("go.rv", result_valid, 1'b0);
      check("go.flag", game_over, 1'b1);
      check("go.amap", attack_map, 35'h6_0002_0001);

      atk_row = 3'd0; atk_col = 3'd0; atk_valid = 1'b1;
      load(35'h0_0000_0F0F);
      atk_valid = 1'b0;
      check("reload.hits", hits_remaining, 6'd8);
      check("reload.amap", attack_map, 35'd0);
      check("reload.hmap", hit_map, 35'd0);
      check("reload.miss", miss_count, 6'd0);
      check("reload.go", game_over, 1'b0);
      @(negedge clk);
      check("coincide.busy", busy, 1'b0);

      attack("lim1", 3'd0, 3'd0, 2'b01, 1'b0, 2'b00, 1'b0);
`ifdef MISS_LIMIT_EN
      attack("lim2", 3'd0, 3'd1, 2'b01, 1'b0, 2'b01, 1'b1);
      check("lim.miss", miss_count, 6'd2);
`else
      attack("lim2", 3'd0, 3'd1, 2'b01, 1'b0, 2'b00, 1'b0);
      attack("lim3", 3'd0, 3'd2, 2'b01, 1'b0, 2'b00, 1'b0);
      check("lim.miss", miss_count, 6'd3);
`endif

      load(35'h0_0000_0F0F);
      atk_row = 3'd6; atk_col = 3'd4; atk_valid = 1'b1;
      @(negedge clk);
      atk_valid = 1'b0;
      @(negedge clk);
      check("clr.pre_rgb", rgb_output, 2'b10);
      #1 clr = 1'b0;
      #1;
      check("clr.rgb", rgb_output, 2'b00);
      check("clr.busy", busy, 1'b0);
      check("clr.hits", hits_remaining, 6'd0);
      check("clr.rv", result_valid, 1'b0);
      check("clr.hmap", hit_map, 35'd0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);

      load(35'd0);
      check("empty.go", game_over, 1'b1);
      check("empty.hits", hits_remaining, 6'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
